// File: rtl/lsu_mem_master.sv
// lsu_mem_master: CPU load/store unit front end driving a 64 KiB byte-addressed memory port.
// Latency: accept -> resp_valid in 2 cycles (IDLE->ACCESS->RESP), 1 cycle when the request faults.
// Backpressure: req_ready only in IDLE; the response is held stable in RESP until resp_ready.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   req_*               CPU request (valid/ready; we, funct3 width code, byte addr, right-aligned wdata)
//   resp_*              CPU response (valid/ready; formatted load data, fault flag)
//   w_en, address,      memory port: byte write enables (bit k -> address+k), byte address,
//   write_data          write data with byte k on [8k+7:8k]
//   read_data           combinational memory read of bytes address..address+3
module lsu_mem_master #(
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [3:0]  w_en,
  output logic [15:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;

  // Request decode: access size minus one (B=0, H=1, W=3) and fault detection.
  logic [1:0]  size_m1;
  logic        code_bad;
  logic        range_bad;
  logic        misalign_bad;
  logic        req_fault;
  logic [16:0] last_byte;
  logic        accept;
  logic [31:0] load_fmt;

  always_comb begin
    size_m1 = 2'd0;
    case (req_funct3[1:0])
      2'd0:    size_m1 = 2'd0;
      2'd1:    size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
  end

  always_comb begin
    code_bad = 1'b1;
    if (req_we) begin
      code_bad = !(req_funct3 == 3'd0 || req_funct3 == 3'd1 || req_funct3 == 3'd2);
    end else begin
      code_bad = !(req_funct3 == 3'd0 || req_funct3 == 3'd1 || req_funct3 == 3'd2 ||
                   req_funct3 == 3'd4 || req_funct3 == 3'd5);
    end
  end

  // A carry out of the 17-bit sum means the access runs past 0xFFFF.
  assign last_byte = {1'b0, req_addr[15:0]} + {15'd0, size_m1};
  assign range_bad = (req_addr[31:16] != 16'd0) || last_byte[16];

  // Halfword needs addr[0]==0, word needs addr[1:0]==0; size_m1 doubles as the alignment mask.
  assign misalign_bad = (ALLOW_MISALIGN == 0) && ((req_addr[1:0] & size_m1) != 2'd0);

  assign req_fault = code_bad || range_bad || misalign_bad;
  assign accept    = (state_q == IDLE) && req_valid;

  // Load formatting: data always sits in the low lanes because address is not lane-shifted.
  always_comb begin
    load_fmt = read_data;
    case (funct3_q)
      3'd0:    load_fmt = {{24{read_data[7]}}, read_data[7:0]};
      3'd4:    load_fmt = {24'd0, read_data[7:0]};
      3'd1:    load_fmt = {{16{read_data[15]}}, read_data[15:0]};
      3'd5:    load_fmt = {16'd0, read_data[15:0]};
      default: load_fmt = read_data;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/strobe outputs. w_en is decoded straight from state so a
  // reset edge during ACCESS drops it immediately after that edge.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    w_en       = 4'b0000;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = req_fault ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          case (funct3_q[1:0])
            2'd0:    w_en = 4'b0001;
            2'd1:    w_en = 4'b0011;
            default: w_en = 4'b1111;
          endcase
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture and response registers. address/write_data are only updated for
  // requests that will actually reach ACCESS, so they otherwise keep their last driven value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      address    <= 16'd0;
      write_data <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q       <= req_we;
        funct3_q   <= req_funct3;
        resp_err   <= req_fault;
        resp_rdata <= 32'd0;
        if (!req_fault) begin
          address <= req_addr[15:0];
          if (req_we) begin
            write_data <= req_wdata;
          end
        end
      end
      if (state_q == ACCESS && !we_q) begin
        resp_rdata <= load_fmt;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: scoreboard bench for lsu_mem_master with a byte memory model.
// Latency: n/a (bench).
// Backpressure: exercises resp_ready hold-off and reset during ACCESS.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_we, resp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, write_data, read_data;
  logic [3:0]  w_en;
  logic [15:0] address;

  // Second instance with strict alignment, sharing the request payload lines.
  logic        req_valid1, resp_ready1;
  logic        req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1, write_data1, read_data1;
  logic [3:0]  w_en1;
  logic [15:0] address1;

  int total = 0;
  int bad   = 0;
  logic [32:0] sb_q[$];
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];

  lsu_mem_master #(.ALLOW_MISALIGN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .w_en(w_en), .address(address), .write_data(write_data), .read_data(read_data)
  );

  lsu_mem_master #(.ALLOW_MISALIGN(0)) dut_strict (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .w_en(w_en1), .address(address1), .write_data(write_data1), .read_data(read_data1)
  );

  assign read_data  = {mem[address + 16'd3], mem[address + 16'd2], mem[address + 16'd1], mem[address]};
  assign read_data1 = {mem[address1 + 16'd3], mem[address1 + 16'd2], mem[address1 + 16'd1], mem[address1]};

  // Memory commits enabled bytes on the clock edge (main instance only).
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_en[k]) mem[address + 16'(k)] = write_data[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  // Reference: returns {err, rdata} for a request, reading the reference memory.
  function automatic logic [32:0] model(input logic we, input logic [2:0] f3,
                                        input logic [31:0] a, input int allow);
    int          sz;
    logic        err;
    logic [31:0] w;
    logic [15:0] b;
    sz  = size_of(f3);
    err = 1'b0;
    if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) err = 1'b1;
    if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) err = 1'b1;
    if (a > 32'h0000_FFFF) err = 1'b1;
    if (int'(a[15:0]) + sz > 65536) err = 1'b1;
    if (allow == 0 && (int'(a[15:0]) % sz) != 0) err = 1'b1;
    if (err || we) return {err, 32'd0};
    b = a[15:0];
    w = {ref_mem[b + 16'd3], ref_mem[b + 16'd2], ref_mem[b + 16'd1], ref_mem[b]};
    case (f3)
      3'd0:    return {1'b0, {24{w[7]}}, w[7:0]};
      3'd4:    return {1'b0, 24'd0, w[7:0]};
      3'd1:    return {1'b0, {16{w[15]}}, w[15:0]};
      3'd5:    return {1'b0, 16'd0, w[15:0]};
      default: return {1'b0, w};
    endcase
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold);
    logic [32:0] e;
    logic [3:0]  ew;
    int          lat;
    e = model(we, f3, a, 1);
    sb_q.push_back(e);
    ew = 4'b0000;
    if (we && !e[32]) ew = (size_of(f3) == 1) ? 4'b0001 : (size_of(f3) == 2) ? 4'b0011 : 4'b1111;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    chk("wen_access", 32'(w_en), 32'(ew));
    if (!e[32]) begin
      chk("addr_access", 32'(address), 32'(a[15:0]));
      if (we) chk("wdata_access", write_data, wd);
    end
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      chk("wen_post", 32'(w_en), 32'd0);
    end
    chk("latency", 32'(lat), e[32] ? 32'd1 : 32'd2);
    if (we && !e[32]) begin
      for (int k = 0; k < size_of(f3); k++) ref_mem[a[15:0] + 16'(k)] = wd[8*k +: 8];
    end
    e = sb_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_vld", 32'(resp_valid), 32'd1);
      chk("hold_rdy", 32'(req_ready), 32'd0);
      chk("hold_data", resp_rdata, e[31:0]);
      chk("hold_err", 32'(resp_err), 32'(e[32]));
    end
    chk("resp_err", 32'(resp_err), 32'(e[32]));
    chk("resp_rdata", resp_rdata, e[31:0]);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk("back_idle", 32'(req_ready), 32'd1);
  endtask

  task automatic do_req1(input logic [2:0] f3, input logic [31:0] a);
    logic [32:0] e;
    int          lat;
    sb_q.push_back(model(1'b0, f3, a, 0));
    @(negedge clk);
    req_valid1 = 1'b1; req_we = 1'b0; req_funct3 = f3; req_addr = a;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    lat = 1;
    while (!resp_valid1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    chk("strict_lat", 32'(lat), e[32] ? 32'd1 : 32'd2);
    chk("strict_err", 32'(resp_err1), 32'(e[32]));
    chk("strict_rdata", resp_rdata1, e[31:0]);
    @(negedge clk); resp_ready1 = 1'b1;
    @(posedge clk); #1; resp_ready1 = 1'b0;
  endtask

  initial begin
    logic [2:0] ld_codes [5];
    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    resp_ready = 1'b0; resp_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_w_en", 32'(w_en), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Word store then load back.
    do_req(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 3'd2, 32'h0000_0100, 32'd0, 0);

    // Preload 0x0200=0x80, 0x0201=0xFF, then the four extension flavours.
    do_req(1'b1, 3'd1, 32'h0000_0200, 32'h0000_FF80, 0);
    do_req(1'b0, 3'd0, 32'h0000_0200, 32'd0, 0);
    do_req(1'b0, 3'd4, 32'h0000_0200, 32'd0, 0);
    do_req(1'b0, 3'd1, 32'h0000_0200, 32'd0, 0);
    do_req(1'b0, 3'd5, 32'h0000_0200, 32'd0, 0);

    // Byte store into the middle of a word; neighbours must stay zero.
    do_req(1'b1, 3'd0, 32'h0000_0301, 32'h1234_5678, 0);
    do_req(1'b0, 3'd2, 32'h0000_0300, 32'd0, 0);

    // Faults: past the top of memory, high address bits, bad codes.
    do_req(1'b0, 3'd2, 32'h0000_FFFE, 32'd0, 0);
    do_req(1'b0, 3'd2, 32'h0001_0000, 32'd0, 0);
    do_req(1'b0, 3'd3, 32'h0000_0100, 32'd0, 0);
    do_req(1'b1, 3'd4, 32'h0000_0100, 32'h1111_1111, 0);
    do_req(1'b1, 3'd1, 32'h0000_FFFF, 32'h2222_2222, 0);

    // Top-of-memory boundary accesses that fit.
    do_req(1'b1, 3'd2, 32'h0000_FFFC, 32'hA1B2_C3D4, 0);
    do_req(1'b0, 3'd0, 32'h0000_FFFF, 32'd0, 0);
    do_req(1'b0, 3'd5, 32'h0000_FFFE, 32'd0, 0);

    // Misaligned halfword is fine on the permissive instance.
    do_req(1'b0, 3'd1, 32'h0000_0101, 32'd0, 0);

    // Response held off for 5 cycles.
    do_req(1'b0, 3'd2, 32'h0000_0100, 32'd0, 5);

    // Strict instance: misaligned halfword faults, aligned accesses do not.
    do_req1(3'd1, 32'h0000_0101);
    do_req1(3'd2, 32'h0000_0102);
    do_req1(3'd2, 32'h0000_0100);
    do_req1(3'd5, 32'h0000_0200);

    // Random traffic in a private window.
    for (int i = 0; i < 24; i++) begin
      logic        we;
      logic [2:0]  f3;
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
      do_req(we, f3, 32'h0000_0500 + 32'($urandom_range(0, 255)), $urandom, 0);
    end

    // Reset while a store sits in ACCESS: everything back to reset values next edge.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h0000_0400; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstacc_wen_before", 32'(w_en), 32'hF);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstacc_req_ready", 32'(req_ready), 32'd1);
    chk("rstacc_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstacc_resp_err", 32'(resp_err), 32'd0);
    chk("rstacc_resp_rdata", resp_rdata, 32'd0);
    chk("rstacc_w_en", 32'(w_en), 32'd0);
    chk("rstacc_address", 32'(address), 32'd0);
    chk("rstacc_write_data", write_data, 32'd0);
    // The reset edge itself still saw w_en high, so the memory took the write.
    for (int k = 0; k < 4; k++) ref_mem[16'h0400 + 16'(k)] = req_wdata[8*k +: 8];
    @(negedge clk); rst_n = 1'b1;
    do_req(1'b0, 3'd2, 32'h0000_0400, 32'd0, 0);
    do_req(1'b0, 3'd2, 32'h0000_0300, 32'd0, 0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
